// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
package tour_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_SNT  = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  // Error status reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_TMO        = 2'd1,
    ERR_BAD_RESP   = 2'd2,
    ERR_EARLY_RESP = 2'd3
  } err_code_e;

  // Classification of a response byte against the current script position.
  typedef enum logic [2:0] {
    RA_NONE     = 3'd0,
    RA_MOVE     = 3'd1,
    RA_ACK_NEXT = 3'd2,
    RA_ACK_LAST = 3'd3,
    RA_BAD      = 3'd4
  } resp_act_e;

  // Response bytes produced by the Knight.
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] MV_ACK  = 8'h5A;

  // Command opcodes understood by the Knight command decoder.
  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [15:0] TOUR     = 16'h7000;

  // Saturating 8-bit increment used for the per-command move counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/seq_script_ram.sv
// Script storage: DEPTH x 16-bit register file, synchronous write, asynchronous read.
module seq_script_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Store a script entry; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a loaded script of Knight commands through RemoteComm, consuming
// per-move and terminal acknowledge bytes and reporting status.
module tour_cmd_sequencer #(
  parameter int         DEPTH   = 8,
  parameter int         TMO_W   = 24,
  parameter logic [7:0] POS_ACK = tour_seq_pkg::POS_ACK,
  parameter logic [7:0] MV_ACK  = tour_seq_pkg::MV_ACK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [$clog2(DEPTH):0]     num_cmds,
  input  logic [TMO_W-1:0]           tmo_lim,
  input  logic                       go,
  output logic [15:0]                cmd,
  output logic                       snd_cmd,
  input  logic                       cmd_snt,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH)-1:0]   err_idx,
  output logic [$clog2(DEPTH)-1:0]   cur_idx,
  output logic [7:0]                 mv_cnt
);

  import tour_seq_pkg::*;

  localparam int IW = $clog2(DEPTH);

  state_e          state_q;
  logic [15:0]     cmd_q;
  logic            snd_cmd_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  err_code_e       err_code_q;
  logic [IW-1:0]   err_idx_q;
  logic [IW-1:0]   cur_idx_q;
  logic [7:0]      mv_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [IW:0]     num_q;

  logic            ram_we_s;
  logic [IW-1:0]   rd_addr_s;
  logic [15:0]     rd_data_s;
  logic            last_s;
  logic            tmo_hit_s;
  resp_act_e       resp_act_s;

  // Script writes are only accepted while no sequence is running.
  assign ram_we_s = wr_en && (state_q == ST_IDLE);

  // The command register is filled on entry to LOAD so cmd is stable for a
  // full cycle before the snd_cmd strobe: entry 0 from IDLE, otherwise the
  // entry following the one just acknowledged.
  assign rd_addr_s = (state_q == ST_IDLE) ? '0 : (cur_idx_q + IW'(1'b1));

  seq_script_ram #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_script (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // The count is latched at go so the caller may change num_cmds mid-run.
  assign last_s    = ({1'b0, cur_idx_q} == (num_q - (IW+1)'(1'b1)));
  assign tmo_hit_s = (tmo_q == tmo_lim);

  // Classify the incoming response byte relative to the script position.
  always_comb begin
    resp_act_s = RA_NONE;
    if (resp_rdy) begin
      if (resp == MV_ACK) begin
        resp_act_s = RA_MOVE;
      end else if (resp == POS_ACK) begin
        resp_act_s = last_s ? RA_ACK_LAST : RA_ACK_NEXT;
      end else begin
        resp_act_s = RA_BAD;
      end
    end else begin
      resp_act_s = RA_NONE;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 16'h0000;
      snd_cmd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
      cur_idx_q  <= '0;
      mv_cnt_q   <= 8'd0;
      tmo_q      <= '0;
      num_q      <= '0;
    end else begin
      snd_cmd_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
            busy_q     <= 1'b1;
            if (num_cmds == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              num_q     <= num_cmds;
              cur_idx_q <= '0;
              cmd_q     <= rd_data_s;
              mv_cnt_q  <= 8'd0;
              state_q   <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          tmo_q     <= '0;
          snd_cmd_q <= 1'b1;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          tmo_q   <= tmo_q + TMO_W'(1'b1);
          state_q <= ST_WAIT_SNT;
        end
        ST_WAIT_SNT, ST_WAIT_RESP: begin
          if (tmo_hit_s) begin
            // Timeout wins over any response arriving in the same cycle.
            err_q      <= 1'b1;
            err_code_q <= ERR_TMO;
            err_idx_q  <= cur_idx_q;
            done_q     <= 1'b1;
            state_q    <= ST_FINISH;
          end else if ((state_q == ST_WAIT_SNT) && !cmd_snt) begin
            if (resp_rdy) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_EARLY_RESP;
              err_idx_q  <= cur_idx_q;
              done_q     <= 1'b1;
              state_q    <= ST_FINISH;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1'b1);
            end
          end else begin
            // Either already in WAIT_RESP, or cmd_snt this cycle: a response
            // in the same cycle is handled as if in WAIT_RESP.
            case (resp_act_s)
              RA_MOVE: begin
                mv_cnt_q <= sat_inc8(mv_cnt_q);
                tmo_q    <= '0;
                state_q  <= ST_WAIT_RESP;
              end
              RA_ACK_NEXT: begin
                cur_idx_q <= cur_idx_q + IW'(1'b1);
                cmd_q     <= rd_data_s;
                mv_cnt_q  <= 8'd0;
                state_q   <= ST_LOAD;
              end
              RA_ACK_LAST: begin
                done_q  <= 1'b1;
                state_q <= ST_FINISH;
              end
              RA_BAD: begin
                err_q      <= 1'b1;
                err_code_q <= ERR_BAD_RESP;
                err_idx_q  <= cur_idx_q;
                done_q     <= 1'b1;
                state_q    <= ST_FINISH;
              end
              default: begin
                tmo_q   <= tmo_q + TMO_W'(1'b1);
                state_q <= ST_WAIT_RESP;
              end
            endcase
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;
  assign cur_idx  = cur_idx_q;
  assign mv_cnt   = mv_cnt_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer: a RemoteComm/Knight responder
// driven from per-command plans, with expected results derived from the plan.
module tb_tour_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int TMO_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [IW-1:0]     wr_addr = '0;
  logic [15:0]       wr_data = 16'h0000;
  logic [IW:0]       num_cmds = '0;
  logic [TMO_W-1:0]  tmo_lim = '0;
  logic              go = 1'b0;
  logic [15:0]       cmd;
  logic              snd_cmd;
  logic              cmd_snt = 1'b0;
  logic              resp_rdy = 1'b0;
  logic [7:0]        resp = 8'h00;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [IW-1:0]     err_idx;
  logic [IW-1:0]     cur_idx;
  logic [7:0]        mv_cnt;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_cmds(num_cmds), .tmo_lim(tmo_lim), .go(go), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .err_idx(err_idx), .cur_idx(cur_idx), .mv_cnt(mv_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int snd_seen = 0;
  int done_seen = 0;

  // Background pulse counters for snd_cmd and done.
  always @(posedge clk) begin
    if (snd_cmd) snd_seen <= snd_seen + 1;
    if (done)    done_seen <= done_seen + 1;
  end

  // Per-run plan (reference model inputs).
  logic [15:0] script_m [DEPTH];
  int          mv_m [DEPTH];
  bit          snt_with_mv [DEPTH];
  int          n_m;
  int          fail_at;     // -1 when the run should pass
  int          fail_kind;   // 0 pass, 1 timeout, 2 bad byte, 3 early response
  int          ack_dly;     // -1 for random short delay before POS_ACK
  logic [7:0]  bad_byte;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_script();
    for (int i = 0; i < n_m; i++) begin
      wr_en = 1'b1; wr_addr = IW'(i); wr_data = script_m[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Execute one planned sequence and check it against the plan's outcome.
  task automatic run_seq(input int lim, input bit go_busy);
    int lat, t, g, k, base_snd, last, exp_mv, exp_snd;
    tmo_lim  = TMO_W'(lim);
    num_cmds = (IW+1)'(n_m);
    load_script();
    base_snd = snd_seen;
    go = 1'b1; tick(); go = 1'b0; lat = 1;
    for (int i = 0; i < n_m; i++) begin
      while (!snd_cmd && lat < 20) begin tick(); lat++; end
      chk("snd_latency", lat, 2);
      chk("cmd_word", cmd, script_m[i]);
      if (i == fail_at && fail_kind == 3) begin
        idle($urandom_range(1, 4));
        resp = 8'($urandom_range(0, 255)); resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
        break;
      end
      t = 0;                              // cycles since the timer last read zero
      g = $urandom_range(1, 5); idle(g); t += g;
      cmd_snt = 1'b1; k = 0;
      if (snt_with_mv[i] && mv_m[i] > 0) begin resp = 8'h5A; resp_rdy = 1'b1; k = 1; end
      tick(); cmd_snt = 1'b0; resp_rdy = 1'b0;
      t = (k == 1) ? 0 : t + 1;
      if (go_busy && i == 0) begin
        go = 1'b1; num_cmds = '0;
        wr_en = 1'b1; wr_addr = IW'(n_m - 1); wr_data = ~script_m[n_m - 1];
        tick();
        go = 1'b0; wr_en = 1'b0; num_cmds = (IW+1)'(n_m); t++;
      end
      for (; k < mv_m[i]; k++) begin
        idle($urandom_range(0, 3));
        resp = 8'h5A; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0; t = 0;
      end
      if (i == fail_at && fail_kind == 1) begin
        lat = t;
        while (!done && lat < lim + 10) begin tick(); lat++; end
        chk("tmo_latency", lat, lim + 1);
        break;
      end
      idle((ack_dly >= 0) ? ack_dly : $urandom_range(0, 4));
      resp = (i == fail_at && fail_kind == 2) ? bad_byte : 8'hA5;
      resp_rdy = 1'b1; tick(); resp_rdy = 1'b0; lat = 1;
      if (i == fail_at && fail_kind == 2) break;
    end
    // Reference outcome from the plan.
    last    = (fail_kind == 0) ? n_m - 1 : fail_at;
    exp_snd = last + 1;
    exp_mv  = (fail_kind == 3) ? 0 : ((mv_m[last] > 255) ? 255 : mv_m[last]);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 1);
    chk("err", err, (fail_kind != 0) ? 1 : 0);
    chk("err_code", err_code, fail_kind);
    chk("err_idx", err_idx, (fail_kind != 0) ? fail_at : 0);
    chk("cur_idx", cur_idx, last);
    chk("mv_cnt", mv_cnt, exp_mv);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    idle(3);
    chk("snd_count", snd_seen - base_snd, exp_snd);
  endtask

  task automatic plan_clear();
    for (int i = 0; i < DEPTH; i++) begin
      script_m[i] = 16'($urandom_range(0, 65535)); mv_m[i] = 0; snt_with_mv[i] = 1'b0;
    end
    fail_at = -1; fail_kind = 0; ack_dly = -1; bad_byte = 8'h33;
  endtask

  initial begin
    int base_snd, base_done, lat;
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_snd", snd_cmd, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_err", {err, err_code, err_idx, cur_idx, mv_cnt, done}, 0);
    rst = 1'b0;
    tick();

    // Single CAL_GYRO, acknowledged 200 clocks after cmd_snt.
    plan_clear(); n_m = 1; script_m[0] = 16'h2000; ack_dly = 200;
    run_seq(1000, 1'b0);

    // CAL_GYRO then tour command with 24 moves; go/write while busy ignored.
    plan_clear(); n_m = 2; script_m[0] = 16'h2000; script_m[1] = 16'h7030; mv_m[1] = 24;
    run_seq(1000, 1'b1);

    // Silence after cmd_snt -> timeout on command 0.
    plan_clear(); n_m = 1; script_m[0] = 16'h2000; fail_at = 0; fail_kind = 1;
    run_seq(1000, 1'b0);

    // Second command answered with a bad byte.
    plan_clear(); n_m = 3; script_m[0] = 16'h2000; script_m[1] = 16'h7030;
    fail_at = 1; fail_kind = 2; bad_byte = 8'h33;
    run_seq(1000, 1'b0);

    // Response before cmd_snt.
    plan_clear(); n_m = 2; fail_at = 0; fail_kind = 3;
    run_seq(1000, 1'b0);

    // num_cmds = 0: immediate done, error cleared, no snd_cmd.
    base_snd = snd_seen; num_cmds = '0;
    go = 1'b1; tick(); go = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_err", {err, err_code}, 0);
    tick();
    chk("zero_done_end", {done, busy}, 0);
    idle(3);
    chk("zero_snd", snd_seen - base_snd, 0);

    // Move counter saturates at 255.
    plan_clear(); n_m = 1; mv_m[0] = 260;
    run_seq(1000, 1'b0);

    // Randomised plans.
    for (int r = 0; r < 10; r++) begin
      plan_clear();
      n_m = $urandom_range(1, DEPTH);
      for (int i = 0; i < n_m; i++) begin
        mv_m[i] = $urandom_range(0, 20); snt_with_mv[i] = ($urandom_range(0, 2) == 0);
      end
      fail_kind = $urandom_range(0, 3);
      fail_at = (fail_kind != 0) ? $urandom_range(0, n_m - 1) : -1;
      bad_byte = 8'($urandom_range(0, 255));
      if (bad_byte == 8'h5A || bad_byte == 8'hA5) bad_byte = 8'h33;
      run_seq($urandom_range(30, 80), r[0]);
    end

    // Reset while waiting for responses: abort, no done, then clean rerun.
    plan_clear(); n_m = 2; tmo_lim = TMO_W'(1000); num_cmds = 4'd2;
    load_script();
    go = 1'b1; tick(); go = 1'b0; lat = 1;
    while (!snd_cmd && lat < 20) begin tick(); lat++; end
    chk("rst_run_snd", lat, 2);
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    resp = 8'h5A; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
    idle(2);
    base_snd = snd_seen; base_done = done_seen;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy_snd", {busy, snd_cmd, done}, 0);
    chk("abort_state", {cur_idx, mv_cnt}, 0);
    idle(30);
    chk("abort_no_done", done_seen - base_done, 0);
    chk("abort_no_snd", snd_seen - base_snd, 0);
    run_seq(1000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
